// File: rtl/slave_fifo_resp.sv
// slave_fifo_resp
// FIFO-backed mailbox responder on the shared two-master bus. Writes to DATA
// push words and reads from DATA pop them. STATUS reports the count and the
// full/empty flags. CTRL bit0 flushes the FIFO. A transfer that cannot
// complete (full, empty or a lock conflict) gets a RETRY response.
//
// Ports
//   CLK     in   bus clock, rising edge
//   RST     in   asynchronous active-low reset
//   SEL     in   slave select from arbiter decode
//   HADDR   in   [15] start, [14:13] slave id (unused), [12] write, [11:0] offset
//   HWDATA  in   write data, valid with HADDR
//   HMAS    in   id of the master owning the bus
//   MLOCK   in   locked-sequence indicator
//   HRDATA  out  read data, valid in the response cycle only
//   HRESP   out  00 OKAY, 01 ERROR, 10 RETRY
//   HREADY  out  0 while a wait state is in progress
//
// state  | meaning
// S_IDLE | no transfer; waiting for SEL with HADDR[15] set
// S_WAIT | wait states after capture; SEL low aborts the transfer
// S_RESP | one response cycle; the FIFO change commits on the closing edge

module slave_fifo_resp #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4,
   parameter int WAIT  = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SEL,
   input  logic [15:0] HADDR,
   input  logic [31:0] HWDATA,
   input  logic [1:0]  HMAS,
   input  logic        MLOCK,
   output logic [31:0] HRDATA,
   output logic [1:0]  HRESP,
   output logic        HREADY
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [11:0]    OFF_DATA   = 12'h000;
   localparam logic [11:0]    OFF_STATUS = 12'h004;
   localparam logic [11:0]    OFF_CTRL   = 12'h008;
   localparam logic [1:0]     RESP_OKAY  = 2'b00;
   localparam logic [1:0]     RESP_ERROR = 2'b01;
   localparam logic [1:0]     RESP_RETRY = 2'b10;
   localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [2:0]     WAIT_LAST  = 3'(WAIT);

   state_t           state, state_nxt;
   logic [2:0]       wait_cnt;
   logic [11:0]      cap_off;
   logic             cap_wr;
   logic [31:0]      cap_wdata;
   logic [1:0]       cap_mas;
   logic             lock_active;
   logic [1:0]       lock_owner;
   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             full, empty;
   logic             start;
   logic             do_push, do_pop, do_flush;
   logic [1:0]       resp_code;
   logic [31:0]      resp_data;
   logic             commit;
   logic             unused_haddr;

   assign unused_haddr = &{1'b0, HADDR[14:13]};

   assign start  = SEL & HADDR[15];
   assign full   = (count == COUNT_FULL);
   assign empty  = (count == '0);
   assign commit = (state == S_RESP);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = (WAIT == 0) ? S_RESP : S_WAIT;
         S_WAIT: begin
            if (!SEL)                       state_nxt = S_IDLE;
            else if (wait_cnt == WAIT_LAST) state_nxt = S_RESP;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      HRDATA = '0;
      HRESP  = RESP_OKAY;
      HREADY = 1'b1;
      case (state)
         S_WAIT: HREADY = 1'b0;
         S_RESP: begin
            HRESP  = resp_code;
            HRDATA = resp_data;
         end
         default: ;
      endcase
   end

   // Capture the transfer; wait_cnt starts at 1 so WAIT_LAST is reached
   // after exactly WAIT wait cycles.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wait_cnt  <= '0;
         cap_off   <= '0;
         cap_wr    <= 1'b0;
         cap_wdata <= '0;
         cap_mas   <= '0;
      end else if (state == S_IDLE && start) begin
         wait_cnt  <= 3'd1;
         cap_off   <= HADDR[11:0];
         cap_wr    <= HADDR[12];
         cap_wdata <= HWDATA;
         cap_mas   <= HMAS;
      end else if (state == S_WAIT && wait_cnt != WAIT_LAST) begin
         wait_cnt  <= wait_cnt + 3'd1;
      end
   end

   // Lock owner is the first master that starts a transfer with MLOCK high;
   // it holds until any edge that sees MLOCK low.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         lock_active <= 1'b0;
         lock_owner  <= '0;
      end else if (!MLOCK) begin
         lock_active <= 1'b0;
      end else if (state == S_IDLE && start && !lock_active) begin
         lock_active <= 1'b1;
         lock_owner  <= HMAS;
      end
   end

   // Response decode from captured values and the pre-commit FIFO state.
   always_comb begin
      resp_code = RESP_OKAY;
      resp_data = '0;
      do_push   = 1'b0;
      do_pop    = 1'b0;
      do_flush  = 1'b0;
      if (lock_active && cap_mas != lock_owner) begin
         resp_code = RESP_RETRY;
      end else begin
         case (cap_off)
            OFF_DATA: begin
               if (cap_wr) begin
                  if (full) resp_code = RESP_RETRY;
                  else      do_push   = 1'b1;
               end else begin
                  if (empty) resp_code = RESP_RETRY;
                  else begin
                     resp_data = mem[rd_ptr];
                     do_pop    = 1'b1;
                  end
               end
            end
            OFF_STATUS: begin
               if (cap_wr) resp_code = RESP_ERROR;
               else        resp_data = {16'b0, 14'(count), full, empty};
            end
            OFF_CTRL: begin
               if (cap_wr) do_flush  = cap_wdata[0];
               else        resp_code = RESP_ERROR;
            end
            default: resp_code = RESP_ERROR;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (commit) begin
         if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
         end else if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (commit && do_push) mem[wr_ptr] <= cap_wdata;
   end

endmodule

// File: tb/tb_slave_fifo_resp.sv
module tb_slave_fifo_resp;

   logic        CLK;
   logic        RST;
   logic        SEL;
   logic [15:0] HADDR;
   logic [31:0] HWDATA;
   logic [1:0]  HMAS;
   logic        MLOCK;
   logic [31:0] HRDATA;
   logic [1:0]  HRESP;
   logic        HREADY;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd;
   logic [1:0]  rs;

   slave_fifo_resp #(.DEPTH(16), .PTR_W(4), .WAIT(1)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .SEL    (SEL),
      .HADDR  (HADDR),
      .HWDATA (HWDATA),
      .HMAS   (HMAS),
      .MLOCK  (MLOCK),
      .HRDATA (HRDATA),
      .HRESP  (HRESP),
      .HREADY (HREADY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete transfer; starts and ends 1 time unit after a rising edge.
   task automatic xfer(input logic wr, input logic [11:0] off, input logic [31:0] wd,
                       input logic [1:0] mas, input logic lock, input string tag,
                       output logic [31:0] rdata, output logic [1:0] resp);
      int n;
      SEL    = 1'b1;
      HADDR  = {1'b1, 2'b00, wr, off};
      HWDATA = wd;
      HMAS   = mas;
      MLOCK  = lock;
      @(posedge CLK); #1;
      HADDR[15] = 1'b0;
      n = 0;
      while (HREADY === 1'b0 && n < 20) begin
         n++;
         @(posedge CLK); #1;
      end
      chk({tag, "_wait"}, 32'(n), 32'd1);
      rdata = HRDATA;
      resp  = HRESP;
      @(posedge CLK); #1;
      SEL   = 1'b0;
      HADDR = '0;
   endtask

   initial begin
      RST = 1'b0; SEL = 1'b0; HADDR = '0; HWDATA = '0; HMAS = '0; MLOCK = 1'b0;
      #12;
      chk("rst_hready", 32'(HREADY), 32'd1);
      chk("rst_hresp",  32'(HRESP),  32'd0);
      chk("rst_hrdata", HRDATA,      32'd0);
      RST = 1'b1;
      @(posedge CLK); #1;

      // single write then status
      xfer(1'b1, 12'h000, 32'hDEADBEEF, 2'd0, 1'b0, "w1", rd, rs);
      chk("w1_resp", 32'(rs), 32'd0);
      xfer(1'b0, 12'h004, 32'h0, 2'd0, 1'b0, "st1", rd, rs);
      chk("st1_data", rd, 32'h00000004);
      chk("st1_resp", 32'(rs), 32'd0);
      xfer(1'b0, 12'h000, 32'h0, 2'd0, 1'b0, "r1", rd, rs);
      chk("r1_data", rd, 32'hDEADBEEF);
      xfer(1'b0, 12'h004, 32'h0, 2'd0, 1'b0, "st2", rd, rs);
      chk("st2_data", rd, 32'h00000001);

      // fill, overflow, drain, underflow
      for (int i = 0; i < 16; i++) begin
         xfer(1'b1, 12'h000, 32'(i), 2'd0, 1'b0, "fill", rd, rs);
         chk("fill_resp", 32'(rs), 32'd0);
      end
      xfer(1'b0, 12'h004, 32'h0, 2'd0, 1'b0, "stf", rd, rs);
      chk("full_status", rd, 32'h00000042);
      xfer(1'b1, 12'h000, 32'h11111111, 2'd0, 1'b0, "ovf", rd, rs);
      chk("ovf_resp", 32'(rs), 32'd2);
      for (int i = 0; i < 16; i++) begin
         xfer(1'b0, 12'h000, 32'h0, 2'd0, 1'b0, "drain", rd, rs);
         chk("drain_data", rd, 32'(i));
         chk("drain_resp", 32'(rs), 32'd0);
      end
      xfer(1'b0, 12'h000, 32'h0, 2'd0, 1'b0, "unf", rd, rs);
      chk("unf_resp", 32'(rs), 32'd2);
      chk("unf_data", rd, 32'd0);
      xfer(1'b0, 12'h004, 32'h0, 2'd0, 1'b0, "ste", rd, rs);
      chk("empty_status", rd, 32'h00000001);

      // flush
      xfer(1'b1, 12'h000, 32'h10, 2'd0, 1'b0, "p3a", rd, rs);
      xfer(1'b1, 12'h000, 32'h20, 2'd0, 1'b0, "p3b", rd, rs);
      xfer(1'b1, 12'h000, 32'h30, 2'd0, 1'b0, "p3c", rd, rs);
      xfer(1'b0, 12'h004, 32'h0, 2'd0, 1'b0, "st3", rd, rs);
      chk("three_status", rd, 32'h0000000C);
      xfer(1'b1, 12'h008, 32'h1, 2'd0, 1'b0, "flush", rd, rs);
      chk("flush_resp", 32'(rs), 32'd0);
      xfer(1'b0, 12'h004, 32'h0, 2'd0, 1'b0, "stfl", rd, rs);
      chk("flush_status", rd, 32'h00000001);
      xfer(1'b0, 12'h000, 32'h0, 2'd0, 1'b0, "rfl", rd, rs);
      chk("flush_read_resp", 32'(rs), 32'd2);

      // error decode
      xfer(1'b1, 12'h000, 32'h55, 2'd0, 1'b0, "p55", rd, rs);
      xfer(1'b0, 12'h00C, 32'h0, 2'd0, 1'b0, "e1", rd, rs);
      chk("err_rd_00c", 32'(rs), 32'd1);
      chk("err_rd_00c_data", rd, 32'd0);
      xfer(1'b1, 12'h004, 32'hFFFFFFFF, 2'd0, 1'b0, "e2", rd, rs);
      chk("err_wr_status", 32'(rs), 32'd1);
      xfer(1'b0, 12'h008, 32'h0, 2'd0, 1'b0, "e3", rd, rs);
      chk("err_rd_ctrl", 32'(rs), 32'd1);
      xfer(1'b0, 12'h004, 32'h0, 2'd0, 1'b0, "ste2", rd, rs);
      chk("err_status", rd, 32'h00000004);
      xfer(1'b0, 12'h000, 32'h0, 2'd0, 1'b0, "r55", rd, rs);
      chk("r55_data", rd, 32'h55);

      // lock conflict
      xfer(1'b1, 12'h000, 32'hA5A50001, 2'd1, 1'b1, "lw", rd, rs);
      chk("lock_wr_resp", 32'(rs), 32'd0);
      xfer(1'b0, 12'h000, 32'h0, 2'd2, 1'b1, "lc", rd, rs);
      chk("lock_conf_resp", 32'(rs), 32'd2);
      chk("lock_conf_data", rd, 32'd0);
      MLOCK = 1'b0;
      @(posedge CLK); #1;
      xfer(1'b0, 12'h000, 32'h0, 2'd2, 1'b0, "lr", rd, rs);
      chk("unlock_resp", 32'(rs), 32'd0);
      chk("unlock_data", rd, 32'hA5A50001);

      // abort by dropping SEL in WAIT
      SEL = 1'b1; HADDR = {1'b1, 2'b00, 1'b1, 12'h000}; HWDATA = 32'h77; HMAS = 2'd0;
      @(posedge CLK); #1;
      chk("abort_wait_hready", 32'(HREADY), 32'd0);
      SEL = 1'b0; HADDR = '0;
      @(posedge CLK); #1;
      chk("abort_hready", 32'(HREADY), 32'd1);
      chk("abort_hresp",  32'(HRESP),  32'd0);
      @(posedge CLK); #1;
      xfer(1'b0, 12'h004, 32'h0, 2'd0, 1'b0, "sta", rd, rs);
      chk("abort_status", rd, 32'h00000001);

      // reset in WAIT
      xfer(1'b1, 12'h000, 32'h1, 2'd0, 1'b0, "pr1", rd, rs);
      xfer(1'b1, 12'h000, 32'h2, 2'd0, 1'b0, "pr2", rd, rs);
      SEL = 1'b1; HADDR = {1'b1, 2'b00, 1'b1, 12'h000}; HWDATA = 32'h99;
      @(posedge CLK); #1;
      chk("rstw_wait_hready", 32'(HREADY), 32'd0);
      #2;
      RST = 1'b0;
      #1;
      chk("rstw_hready", 32'(HREADY), 32'd1);
      chk("rstw_hresp",  32'(HRESP),  32'd0);
      chk("rstw_hrdata", HRDATA,      32'd0);
      SEL = 1'b0; HADDR = '0;
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      xfer(1'b0, 12'h004, 32'h0, 2'd0, 1'b0, "str", rd, rs);
      chk("rstw_status", rd, 32'h00000001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
